// File: rtl/pipeline_stat_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Package  : pipeline_stat_pkg
// Brief    : Shared types and defaults for the pipeline statistics monitor.
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_stat_pkg;

  // Monitor FSM encoding; state_o exposes these values directly.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Branch-decision code meaning "flush the pipeline".
  localparam logic [1:0] FLUSH_CODE = 2'd2;

  // Default build-time configuration.
  localparam int DEF_WIDTH       = 32;
  localparam int DEF_CYCLE_LIMIT = 30;
  localparam int DEF_HANG_LIMIT  = 8;

endpackage
`default_nettype wire

// File: rtl/pipeline_stat_monitor_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Enabled up-counter with synchronous clear that sticks at all-ones.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter
  import pipeline_stat_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear wins, otherwise increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_stat_monitor.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_stat_monitor
// Brief    : Counts CPU cycles, stalls and flushes during a run window, flags
//            a stuck PC, and offers a handshake-protected counter snapshot.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_stat_monitor
  import pipeline_stat_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int CYCLE_LIMIT = DEF_CYCLE_LIMIT,
  parameter int HANG_LIMIT  = DEF_HANG_LIMIT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             hazard_i,
  input  logic [1:0]       branch_sel_i,
  input  logic [31:0]      pc_i,
  input  logic             clear_i,
  input  logic             snap_req_i,
  input  logic             snap_ack_i,
  output logic [WIDTH-1:0] cycle_cnt_o,
  output logic [WIDTH-1:0] stall_cnt_o,
  output logic [WIDTH-1:0] flush_cnt_o,
  output logic [WIDTH-1:0] snap_cycle_o,
  output logic [WIDTH-1:0] snap_stall_o,
  output logic [WIDTH-1:0] snap_flush_o,
  output logic             snap_valid_o,
  output logic [1:0]       state_o,
  output logic             done_o,
  output logic             hang_o
);

  // Run-length only needs to reach HANG_LIMIT, then it parks there.
  localparam int               RUN_W     = (HANG_LIMIT < 1) ? 1 : $clog2(HANG_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(HANG_LIMIT);
  localparam logic [WIDTH-1:0] CYC_LIMIT = WIDTH'(CYCLE_LIMIT);
  localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};

  state_e           state_q, state_d;
  logic             sample;
  logic             stall_en;
  logic             flush_en;
  logic [WIDTH-1:0] cyc_upd;
  logic             limit_hit;

  logic [31:0]      prev_pc_q, prev_pc_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             hang_q, hang_d;

  logic             snap_valid_q, snap_valid_d;
  logic [WIDTH-1:0] snap_cycle_q, snap_cycle_d;
  logic [WIDTH-1:0] snap_stall_q, snap_stall_d;
  logic [WIDTH-1:0] snap_flush_q, snap_flush_d;

  // A clear in the same cycle cancels the sample so nothing counts.
  assign sample   = (state_q == ST_RUN) && start_i && !clear_i;
  assign stall_en = sample && hazard_i;
  assign flush_en = sample && (branch_sel_i == FLUSH_CODE);

  // Value cycle_cnt will hold after this sample, used to stop exactly on the limit.
  assign cyc_upd   = (cycle_cnt_o == CNT_MAX) ? cycle_cnt_o : cycle_cnt_o + WIDTH'(1);
  assign limit_hit = (CYCLE_LIMIT != 0) && (cyc_upd == CYC_LIMIT);

  sat_counter #(.WIDTH(WIDTH)) u_cycle_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clear_i),
    .en_i  (sample),
    .cnt_o (cycle_cnt_o)
  );

  sat_counter #(.WIDTH(WIDTH)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clear_i),
    .en_i  (stall_en),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.WIDTH(WIDTH)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clear_i),
    .en_i  (flush_en),
    .cnt_o (flush_cnt_o)
  );

  // Next-state: IDLE waits for start, RUN stops on the cycle limit, DONE waits for clear.
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start_i) state_d = ST_RUN;
        ST_RUN:  if (sample && limit_hit) state_d = ST_DONE;
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Hang tracker: stalled samples hold the run-length, others compare against the last PC.
  always_comb begin
    prev_pc_d = prev_pc_q;
    run_d     = run_q;
    hang_d    = hang_q;
    if (clear_i) begin
      prev_pc_d = '0;
      run_d     = '0;
      hang_d    = 1'b0;
    end else if (sample) begin
      prev_pc_d = pc_i;
      if (!hazard_i) begin
        if (pc_i == prev_pc_q) begin
          if (run_q != RUN_LIMIT) begin
            run_d = run_q + RUN_W'(1);
          end
        end else begin
          run_d = '0;
        end
      end
      if (run_d == RUN_LIMIT) begin
        hang_d = 1'b1;
      end
    end
  end

  // Hang tracker registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      prev_pc_q <= '0;
      run_q     <= '0;
      hang_q    <= 1'b0;
    end else begin
      prev_pc_q <= prev_pc_d;
      run_q     <= run_d;
      hang_q    <= hang_d;
    end
  end

  // Snapshot handshake: capture only when empty; an ack frees it without re-arming that edge.
  always_comb begin
    snap_valid_d = snap_valid_q;
    snap_cycle_d = snap_cycle_q;
    snap_stall_d = snap_stall_q;
    snap_flush_d = snap_flush_q;
    if (clear_i) begin
      snap_valid_d = 1'b0;
    end else if (snap_valid_q) begin
      if (snap_ack_i) begin
        snap_valid_d = 1'b0;
      end
    end else if (snap_req_i) begin
      snap_valid_d = 1'b1;
      snap_cycle_d = cycle_cnt_o;
      snap_stall_d = stall_cnt_o;
      snap_flush_d = flush_cnt_o;
    end
  end

  // Snapshot registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      snap_valid_q <= 1'b0;
      snap_cycle_q <= '0;
      snap_stall_q <= '0;
      snap_flush_q <= '0;
    end else begin
      snap_valid_q <= snap_valid_d;
      snap_cycle_q <= snap_cycle_d;
      snap_stall_q <= snap_stall_d;
      snap_flush_q <= snap_flush_d;
    end
  end

  assign state_o      = state_q;
  assign done_o       = (state_q == ST_DONE);
  assign hang_o       = hang_q;
  assign snap_valid_o = snap_valid_q;
  assign snap_cycle_o = snap_cycle_q;
  assign snap_stall_o = snap_stall_q;
  assign snap_flush_o = snap_flush_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stat_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_stat_monitor
// Brief    : Self-checking bench: vector table plus model-driven scoreboard,
//            with directed sequences for limits, hang, snapshot and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_stat_monitor;
  import pipeline_stat_pkg::*;

  localparam int CL = 30;
  localparam int HL = 8;

  typedef struct packed {
    logic        start;
    logic        hazard;
    logic [1:0]  br;
    logic [31:0] pc;
    logic        clear;
    logic        req;
    logic        ack;
  } stim_t;

  typedef struct packed {
    logic [1:0]  state;
    logic        done;
    logic        hang;
    logic        sv;
    logic [31:0] cyc;
    logic [31:0] stl;
    logic [31:0] fl;
    logic [31:0] scyc;
    logic [31:0] sstl;
    logic [31:0] sfl;
  } obs_t;

  typedef struct packed {
    stim_t s;
    obs_t  e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, start, hazard, clear, req, ack, start4;
  logic [1:0]  br;
  logic [31:0] pc;

  logic [31:0] cyc, stl, fl, scyc, sstl, sfl;
  logic        sv, done, hang;
  logic [1:0]  st;
  logic [3:0]  cyc4, stl4, fl4, scyc4, sstl4, sfl4;
  logic        sv4, done4, hang4;
  logic [1:0]  st4;

  int n_tests = 0;
  int n_fail  = 0;

  obs_t        m;
  logic [31:0] m_prev;
  int          m_run;
  obs_t        sb[$];
  vec_t        tbl[10];

  always #5 clk = ~clk;

  pipeline_stat_monitor #(.WIDTH(32), .CYCLE_LIMIT(CL), .HANG_LIMIT(HL)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .hazard_i(hazard),
    .branch_sel_i(br), .pc_i(pc), .clear_i(clear),
    .snap_req_i(req), .snap_ack_i(ack),
    .cycle_cnt_o(cyc), .stall_cnt_o(stl), .flush_cnt_o(fl),
    .snap_cycle_o(scyc), .snap_stall_o(sstl), .snap_flush_o(sfl),
    .snap_valid_o(sv), .state_o(st), .done_o(done), .hang_o(hang)
  );

  pipeline_stat_monitor #(.WIDTH(4), .CYCLE_LIMIT(0), .HANG_LIMIT(HL)) dut_w4 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start4), .hazard_i(hazard),
    .branch_sel_i(br), .pc_i(pc), .clear_i(clear),
    .snap_req_i(req), .snap_ack_i(ack),
    .cycle_cnt_o(cyc4), .stall_cnt_o(stl4), .flush_cnt_o(fl4),
    .snap_cycle_o(scyc4), .snap_stall_o(sstl4), .snap_flush_o(sfl4),
    .snap_valid_o(sv4), .state_o(st4), .done_o(done4), .hang_o(hang4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic stim_t S(input logic s_st, input logic s_hz, input logic [1:0] s_br,
                              input logic [31:0] s_pc, input logic s_c, input logic s_r,
                              input logic s_a);
    stim_t s;
    s.start = s_st; s.hazard = s_hz; s.br = s_br; s.pc = s_pc;
    s.clear = s_c;  s.req = s_r;     s.ack = s_a;
    return s;
  endfunction

  function automatic vec_t V(input logic v_st, input logic v_hz, input logic [1:0] v_br,
                             input logic v_c, input logic v_r, input logic v_a,
                             input logic [1:0] e_st, input logic [31:0] e_cyc,
                             input logic [31:0] e_stl, input logic [31:0] e_fl,
                             input logic e_sv, input logic [31:0] e_scyc,
                             input logic [31:0] e_sstl, input logic [31:0] e_sfl);
    vec_t v;
    v.s      = S(v_st, v_hz, v_br, 32'h0, v_c, v_r, v_a);
    v.e      = '0;
    v.e.state = e_st;
    v.e.done = (e_st == 2'd2);
    v.e.sv   = e_sv;
    v.e.cyc  = e_cyc;  v.e.stl  = e_stl;  v.e.fl  = e_fl;
    v.e.scyc = e_scyc; v.e.sstl = e_sstl; v.e.sfl = e_sfl;
    return v;
  endfunction

  function automatic logic [31:0] inc_sat(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  task automatic model_reset();
    m      = '0;
    m_prev = '0;
    m_run  = 0;
  endtask

  // Reference behaviour for one rising edge of the default-configured monitor.
  task automatic model_step(input stim_t s);
    obs_t n;
    n = m;
    if (s.clear) begin
      n.state = 2'd0; n.cyc = '0; n.stl = '0; n.fl = '0;
      n.hang = 1'b0;  n.sv = 1'b0;
      m_run = 0;      m_prev = '0;
    end else begin
      if (m.sv) begin
        if (s.ack) n.sv = 1'b0;
      end else if (s.req) begin
        n.sv = 1'b1; n.scyc = m.cyc; n.sstl = m.stl; n.sfl = m.fl;
      end
      if (m.state == 2'd0) begin
        if (s.start) n.state = 2'd1;
      end else if (m.state == 2'd1 && s.start) begin
        n.cyc = inc_sat(m.cyc);
        if (s.hazard)      n.stl = inc_sat(m.stl);
        if (s.br == 2'd2)  n.fl  = inc_sat(m.fl);
        if (!s.hazard) m_run = (s.pc == m_prev) ? m_run + 1 : 0;
        m_prev = s.pc;
        if (m_run >= HL) n.hang = 1'b1;
        if (n.cyc == 32'(CL)) n.state = 2'd2;
      end
    end
    n.done = (n.state == 2'd2);
    m = n;
  endtask

  task automatic compare(input obs_t e, input string tag);
    chk({tag, ".state"}, 32'(st),   32'(e.state));
    chk({tag, ".done"},  32'(done), 32'(e.done));
    chk({tag, ".hang"},  32'(hang), 32'(e.hang));
    chk({tag, ".sv"},    32'(sv),   32'(e.sv));
    chk({tag, ".cyc"},   cyc,  e.cyc);
    chk({tag, ".stall"}, stl,  e.stl);
    chk({tag, ".flush"}, fl,   e.fl);
    chk({tag, ".scyc"},  scyc, e.scyc);
    chk({tag, ".sstl"},  sstl, e.sstl);
    chk({tag, ".sfl"},   sfl,  e.sfl);
  endtask

  task automatic drive(input stim_t s);
    @(negedge clk);
    start = s.start; hazard = s.hazard; br = s.br; pc = s.pc;
    clear = s.clear; req = s.req; ack = s.ack;
  endtask

  task automatic step(input stim_t s, input string tag);
    drive(s);
    model_step(s);
    sb.push_back(m);
    @(posedge clk); #1;
    compare(sb.pop_front(), tag);
  endtask

  // Reset asserted between edges so the outputs must clear without a clock.
  task automatic do_reset(input string tag);
    @(negedge clk); #2;
    start = 0; hazard = 0; br = 2'd0; pc = '0; clear = 0; req = 0; ack = 0;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare(m, tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = V(1,0,2'd0,0,0,0, 2'd1, 0,0,0, 0, 0,0,0);
    tbl[1] = V(1,1,2'd0,0,0,0, 2'd1, 1,1,0, 0, 0,0,0);
    tbl[2] = V(1,0,2'd2,0,0,0, 2'd1, 2,1,1, 0, 0,0,0);
    tbl[3] = V(1,1,2'd2,0,0,0, 2'd1, 3,2,2, 0, 0,0,0);
    tbl[4] = V(0,0,2'd0,0,1,0, 2'd1, 3,2,2, 1, 3,2,2);
    tbl[5] = V(1,0,2'd0,0,0,0, 2'd1, 4,2,2, 1, 3,2,2);
    tbl[6] = V(1,0,2'd0,0,1,1, 2'd1, 5,2,2, 0, 3,2,2);
    tbl[7] = V(1,0,2'd0,0,1,0, 2'd1, 6,2,2, 1, 5,2,2);
    tbl[8] = V(1,0,2'd0,1,1,0, 2'd0, 0,0,0, 0, 5,2,2);
    tbl[9] = V(0,0,2'd0,0,0,0, 2'd0, 0,0,0, 0, 5,2,2);

    rst_n = 1'b1; start4 = 1'b0;
    start = 0; hazard = 0; br = 2'd0; pc = '0; clear = 0; req = 0; ack = 0;
    do_reset("reset0");

    // Hand-computed vector table: pause, stall+flush overlap, snapshot handshake, clear.
    for (int i = 0; i < 10; i++) begin
      stim_t s;
      s = tbl[i].s;
      s.pc = 32'h100 + 32'(4 * i);
      drive(s);
      model_step(s);
      sb.push_back(tbl[i].e);
      @(posedge clk); #1;
      compare(sb.pop_front(), $sformatf("vec%0d", i));
    end

    // Full 30-cycle run from reset: stalls on samples 5-6, flush on sample 10.
    do_reset("reset1");
    step(S(1,0,2'd0,32'h2000,0,0,0), "run_go");
    for (int k = 1; k <= CL; k++)
      step(S(1, (k == 5 || k == 6), (k == 10) ? 2'd2 : 2'd0, 32'h2000 + 32'(4 * k), 0,0,0),
           $sformatf("run%0d", k));
    chk("run.state_done", 32'(st), 32'd2);
    chk("run.done_o",     32'(done), 32'd1);
    chk("run.cycle30",    cyc, 32'd30);
    chk("run.stall2",     stl, 32'd2);
    chk("run.flush1",     fl,  32'd1);
    for (int k = 0; k < 2; k++)
      step(S(1,1,2'd2,32'h3000 + 32'(k),0,0,0), $sformatf("done_hold%0d", k));
    chk("done.no_count", cyc, 32'd30);

    // Stall and flush together on three samples.
    step(S(0,0,2'd0,32'h0,1,0,0), "both_clr");
    step(S(1,0,2'd0,32'h10,0,0,0), "both_go");
    for (int k = 0; k < 3; k++)
      step(S(1,1,2'd2,32'h20 + 32'(4 * k),0,0,0), $sformatf("both%0d", k));
    chk("both.stall3", stl, 32'd3);
    chk("both.flush3", fl,  32'd3);

    // Constant PC without stalls: hang after the 8th sample, not the 7th.
    step(S(0,0,2'd0,32'h0,1,0,0), "hangA_clr");
    step(S(1,0,2'd0,32'h0,0,0,0), "hangA_go");
    for (int k = 1; k <= HL; k++) begin
      step(S(1,0,2'd0,32'h0,0,0,0), $sformatf("hangA%0d", k));
      if (k == HL - 1) chk("hangA.before", 32'(hang), 32'd0);
    end
    chk("hangA.set", 32'(hang), 32'd1);

    // Alternate stalls: only the non-stall samples advance the run-length.
    step(S(0,0,2'd0,32'h0,1,0,0), "hangB_clr");
    chk("hangB.cleared", 32'(hang), 32'd0);
    step(S(1,0,2'd0,32'h0,0,0,0), "hangB_go");
    for (int k = 1; k <= 2 * HL; k++) begin
      step(S(1, k[0], 2'd0, 32'h0, 0,0,0), $sformatf("hangB%0d", k));
      if (k == 2 * HL - 1) chk("hangB.before", 32'(hang), 32'd0);
    end
    chk("hangB.set", 32'(hang), 32'd1);

    // Snapshot at cycle 7, held through requests, ack+req frees without re-capture.
    step(S(0,0,2'd0,32'h0,1,0,0), "snap_clr");
    step(S(1,0,2'd0,32'h400,0,0,0), "snap_go");
    for (int k = 1; k <= 7; k++)
      step(S(1,0,2'd0,32'h400 + 32'(4 * k),0,0,0), $sformatf("snap_run%0d", k));
    chk("snap.cyc7", cyc, 32'd7);
    step(S(1,0,2'd0,32'h440,0,1,0), "snap_req");
    for (int k = 0; k < 2; k++)
      step(S(1,0,2'd0,32'h450 + 32'(4 * k),0,1,0), $sformatf("snap_hold%0d", k));
    chk("snap.held7", scyc, 32'd7);
    chk("snap.valid", 32'(sv), 32'd1);
    step(S(1,0,2'd0,32'h460,0,1,1), "snap_ackreq");
    chk("snap.ack_clears", 32'(sv), 32'd0);
    step(S(1,0,2'd0,32'h464,0,0,0), "snap_idle");
    chk("snap.no_new", 32'(sv), 32'd0);
    step(S(1,0,2'd0,32'h468,0,1,0), "snap_again");

    // Reset mid-run with a pending snapshot.
    step(S(0,0,2'd0,32'h0,1,0,0), "mid_clr");
    step(S(1,0,2'd0,32'h500,0,0,0), "mid_go");
    for (int k = 1; k <= 12; k++)
      step(S(1,0,2'd0,32'h500 + 32'(4 * k),0,0,0), $sformatf("mid%0d", k));
    step(S(1,0,2'd0,32'h540,0,1,0), "mid_snap");
    chk("mid.snap12", scyc, 32'd12);
    do_reset("mid_reset");
    chk("mid.state0", 32'(st), 32'd0);

    // Clear out of DONE.
    step(S(1,0,2'd0,32'h600,0,0,0), "dclr_go");
    for (int k = 1; k <= CL; k++)
      step(S(1,0,2'd0,32'h600 + 32'(4 * k),0,0,0), $sformatf("dclr%0d", k));
    chk("dclr.in_done", 32'(st), 32'd2);
    step(S(1,0,2'd0,32'h700,1,0,0), "dclr_clear");
    chk("dclr.idle", 32'(st), 32'd0);
    chk("dclr.cyc0", cyc, 32'd0);

    // Narrow counter with no cycle limit saturates instead of wrapping.
    step(S(0,0,2'd0,32'h0,1,0,0), "w4_clr");
    start4 = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      step(S(0,1,2'd0,32'h0,0,0,0), $sformatf("w4_%0d", k));
      if (k == 14) chk("w4.cyc14", 32'(cyc4), 32'd14);
      if (k == 15) chk("w4.cyc15", 32'(cyc4), 32'd15);
    end
    chk("w4.cyc_sat",   32'(cyc4),  32'd15);
    chk("w4.stall_sat", 32'(stl4),  32'd15);
    chk("w4.flush",     32'(fl4),   32'd0);
    chk("w4.state_run", 32'(st4),   32'd1);
    chk("w4.done",      32'(done4), 32'd0);
    chk("w4.hang",      32'(hang4), 32'd0);
    chk("w4.sv",        32'(sv4),   32'd0);
    chk("w4.snap",      32'({scyc4, sstl4, sfl4}), 32'd0);
    start4 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_stat_monitor.md
PIPELINE_STAT_MONITOR -- requirements
Module: pipeline_stat_monitor

Interface
REQ-001 Parameter WIDTH, 32, counter and snapshot width.
REQ-002 Parameter CYCLE_LIMIT, 30, RUN cycles before DONE; 0 = unlimited.
REQ-003 Parameter HANG_LIMIT, 8, consecutive unchanged-PC non-stall cycles that flag a hang.
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-low.
REQ-006 start_i  in  1  CPU start; enables sampling.
REQ-007 hazard_i  in  1  hazard-unit stall indication for the current cycle.
REQ-008 branch_sel_i  in  2  branch-decision code; value 2'd2 = pipeline flush.
REQ-009 pc_i  in  32  current PC register output.
REQ-010 clear_i  in  1  synchronous clear of counters, flags and state.
REQ-011 snap_req_i / snap_ack_i  in  1 each  snapshot request / consumer acknowledge.
REQ-012 cycle_cnt_o, stall_cnt_o, flush_cnt_o  out  WIDTH each  live counters.
REQ-013 snap_cycle_o, snap_stall_o, snap_flush_o  out  WIDTH each  snapshot registers.
REQ-014 snap_valid_o  out  1  snapshot held; state_o  out  2  FSM state; done_o  out  1  limit reached; hang_o  out  1  sticky hang flag.

Function
REQ-015 FSM states IDLE=0, RUN=1, DONE=2; state_o reflects the registered state.
REQ-016 IDLE->RUN at the edge where start_i=1; no counting at that edge.
REQ-017 A sample cycle is an edge with state RUN and start_i=1; start_i=0 in RUN pauses all counters and the hang tracker without leaving RUN.
REQ-018 Each sample cycle: cycle_cnt +1; stall_cnt +1 if hazard_i; flush_cnt +1 if branch_sel_i==2; stall and flush in the same cycle both increment.
REQ-019 All counters saturate at 2^WIDTH-1; no wrap.
REQ-020 RUN->DONE at the sample edge where the updated cycle_cnt equals CYCLE_LIMIT (CYCLE_LIMIT!=0); that edge's increments are kept; done_o=1 exactly while in DONE.
REQ-021 No counting in IDLE or DONE; DONE is left only by clear_i or reset.
REQ-022 clear_i=1: next state IDLE, all counters, hang tracker, hang_o and snap_valid_o to 0; clear_i overrides start_i, snap_req_i and counting in the same edge.
REQ-023 Hang tracker: on sample cycles with hazard_i=0, pc_i equal to the previously sampled PC increments a run-length, else reloads 0; stall sample cycles hold the run-length; hang_o sets when run-length reaches HANG_LIMIT and stays set until clear.
REQ-024 Snapshot: snap_req_i=1 with snap_valid_o=0 latches the pre-edge live counter values into snap_*_o and sets snap_valid_o at the next edge.
REQ-025 snap_*_o hold stable while snap_valid_o=1; snap_req_i is ignored then.
REQ-026 snap_ack_i=1 with snap_valid_o=1 clears snap_valid_o at that edge; a simultaneous snap_req_i is ignored (minimum one idle cycle between snapshots).
REQ-027 Snapshots are allowed in any FSM state.

Reset
REQ-028 rst_i=0 asynchronously forces IDLE, all counters, snapshot registers, previous-PC, run-length, snap_valid_o, done_o and hang_o to 0, including mid-RUN or with a pending snapshot.
REQ-029 After rst_i release the first possible transition is IDLE->RUN at the next edge with start_i=1.

Structure
REQ-030 Package pipeline_stat_pkg holds the state enumeration, FLUSH_CODE=2'd2 and the default WIDTH/CYCLE_LIMIT/HANG_LIMIT constants.
REQ-031 One sub-module sat_counter (WIDTH-parameterised, enable, synchronous clear, saturating) instantiated three times; FSM, hang tracker and snapshot logic reside in the top.

Verification
REQ-032 Reset, start_i=1, 30 cycles, hazard_i high on cycles 5-6, branch_sel_i=2 on cycle 10 -> DONE, done_o=1, cycle=30, stall=2, flush=1.
REQ-033 hazard_i=1 and branch_sel_i=2 together for 3 sample cycles -> stall=3, flush=3.
REQ-034 pc_i constant, hazard_i=0, 8 sample cycles -> hang_o=1 after the 8th; same stimulus with hazard_i=1 every other cycle -> hang_o stays 0 until 8 non-stall samples.
REQ-035 snap_req_i at cycle_cnt=7, counting continues -> snap_cycle_o=7 held; snap_ack_i with snap_req_i same edge -> snap_valid_o=0, no new snapshot.
REQ-036 rst_i low mid-RUN at cycle 12 with snap_valid_o=1 -> all outputs 0 immediately, state_o=0; clear_i in DONE -> IDLE, counters 0.
REQ-037 WIDTH=4, CYCLE_LIMIT=0, 20 sample cycles -> cycle_cnt_o saturates at 15.
